// File: rtl/mult_pkg.sv
// Shared definitions for the iterative HI/LO multiplier: widths, mfReg
// selector codes and FSM state encodings.
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 32;
  localparam int unsigned MULT_CNT_W = 5;

  // mfReg selector codes driven by the decode of MFHI/MFLO
  localparam logic [1:0] MF_HI = 2'b01;
  localparam logic [1:0] MF_LO = 2'b10;

  // FSM state encodings (plain constants so older netlists keep the same codes)
  typedef logic [1:0] multState_t;
  localparam multState_t IDLE = 2'd0;
  localparam multState_t CALC = 2'd1;
  localparam multState_t SIGN = 2'd2;

endpackage

// File: rtl/mult_unit_if.sv
// Execute-stage <-> multiplier signal bundle. The pipeline side is the
// master, the multiplier is the slave.
interface mult_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic             multStart;
  logic             multSigned;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             StallE;
  logic [1:0]       mfReg;
  logic             multReady;
  logic             multBusy;
  logic [WIDTH-1:0] HiLoOut;

  modport master (
    output multStart, multSigned, SrcAE, SrcBE, StallE, mfReg,
    input  multReady, multBusy, HiLoOut
  );

  modport slave (
    input  multStart, multSigned, SrcAE, SrcBE, StallE, mfReg,
    output multReady, multBusy, HiLoOut
  );

endinterface

// File: rtl/mult_unit_shift_add_core.sv
// Shift-add datapath: multiplicand, multiplier shift register, 64-bit
// accumulator with a 33-bit adder, and last-step detection.
// Optional feature macro: MULT_EARLY_EXIT_EN (stop once the remaining
// multiplier bits are all zero and realign the accumulator in one shift).
module shift_add_core import mult_pkg::*; #(
  parameter int unsigned WIDTH = MULT_WIDTH,
  parameter int unsigned CntW  = MULT_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcandIn,
  input  logic [WIDTH-1:0]   mplierIn,
  input  logic [CntW-1:0]    count,
  output logic [2*WIDTH-1:0] acc,
  output logic               lastStep
);

  localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] accStep;
  logic [2*WIDTH-1:0] accNext;
  logic [WIDTH-1:0]   mplierStep;

  // One shift-add step: add into the upper half keeping the carry, then shift right
  always_comb begin
    sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    accStep    = {sum, acc[WIDTH-1:1]};
    mplierStep = mplier >> 1;
  end

`ifdef MULT_EARLY_EXIT_EN
  logic [CntW-1:0] realignAmt;

  // Finish as soon as no multiplier bits remain; skipped shifts are applied at once
  always_comb begin
    realignAmt = LastCount - count;
    lastStep   = (mplierStep == '0);
    accNext    = lastStep ? (accStep >> realignAmt) : accStep;
  end
`else
  // Fixed-length iteration: one step per multiplier bit
  always_comb begin
    lastStep = (count == LastCount);
    accNext  = accStep;
  end
`endif

  // Operand capture on load, one step per cycle while stepping
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= mcandIn;
      mplier <= mplierIn;
      acc    <= '0;
    end else if (step) begin
      mplier <= mplierStep;
      acc    <= accNext;
    end
  end

endmodule

// File: rtl/mult_unit.sv
// Iterative MULT/MULTU unit for the Execute stage. Owns the FSM, sign
// handling and the HI/LO registers; the shift-add datapath lives in
// shift_add_core. Optional feature macro: MULT_EARLY_EXIT_EN (see core).
module mult_unit import mult_pkg::*; #(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input logic        clk,
  input logic        reset,
  mult_unit_if.slave bus
);

  multState_t             state;
  multState_t             stateNext;
  logic [MULT_CNT_W-1:0]  count;
  logic                   negResult;
  logic [WIDTH-1:0]       hi;
  logic [WIDTH-1:0]       lo;
  logic                   accept;
  logic                   step;
  logic                   lastStep;
  logic [WIDTH-1:0]       absA;
  logic [WIDTH-1:0]       absB;
  logic [2*WIDTH-1:0]     acc;
  logic [2*WIDTH-1:0]     product;

  // Start acceptance and operand magnitudes; 0x80000000 stays as unsigned 2^31
  always_comb begin
    accept  = bus.multStart && !bus.StallE;
    step    = (state == CALC) && !accept;
    absA    = (bus.multSigned && bus.SrcAE[WIDTH-1]) ? -bus.SrcAE : bus.SrcAE;
    absB    = (bus.multSigned && bus.SrcBE[WIDTH-1]) ? -bus.SrcBE : bus.SrcBE;
    product = negResult ? -acc : acc;
  end

  shift_add_core #(
    .WIDTH (WIDTH),
    .CntW  (MULT_CNT_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .step     (step),
    .mcandIn  (absA),
    .mplierIn (absB),
    .count    (count),
    .acc      (acc),
    .lastStep (lastStep)
  );

  // Next state; an accepted start always (re)enters CALC, aborting any product
  always_comb begin
    stateNext = state;
    if (accept) begin
      stateNext = CALC;
    end else begin
      case (state)
        CALC:    if (lastStep) stateNext = SIGN;
        SIGN:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // State, step counter, sign flag and HI/LO write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      negResult <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        count     <= '0;
        negResult <= bus.multSigned && (bus.SrcAE[WIDTH-1] ^ bus.SrcBE[WIDTH-1]);
      end else if (state == CALC) begin
        count <= count + 1'b1;
      end
      if (!accept && state == SIGN) begin
        hi <= product[2*WIDTH-1:WIDTH];
        lo <= product[WIDTH-1:0];
      end
    end
  end

  // Status flags and the MFHI/MFLO read mux
  always_comb begin
    bus.multReady = (state == IDLE);
    bus.multBusy  = (state != IDLE);
    case (bus.mfReg)
      MF_HI:   bus.HiLoOut = hi;
      MF_LO:   bus.HiLoOut = lo;
      default: bus.HiLoOut = '0;
    endcase
  end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed corner products plus random
// MULT/MULTU operands compared against a 64-bit arithmetic reference.
module tb_mult_unit;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   nPass   = 0;
  int   nChecks = 0;

  always #5 clk = ~clk;

  mult_unit_if #(.WIDTH(32)) bus ();

  mult_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference product from plain 64-bit arithmetic
  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  // Cycles from accepted start until HI/LO are valid
  function automatic int refLatency(input logic [31:0] b, input logic sgn);
`ifdef MULT_EARLY_EXIT_EN
    logic [31:0] mag;
    int          top;
    mag = (sgn && b[31]) ? -b : b;
    top = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) top = i;
    return top + 2;
`else
    return 33;
`endif
  endfunction

  // Issue one multiply (optionally held off by StallE), wait for it, check result
  task automatic runMult(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int stallCycles, input string tag);
    logic [63:0] exp;
    logic [31:0] hiVal;
    logic [31:0] loVal;
    int          cycles;
    exp             = refProduct(a, b, sgn);
    bus.SrcAE       = a;
    bus.SrcBE       = b;
    bus.multSigned  = sgn;
    bus.multStart   = 1'b1;
    bus.StallE      = (stallCycles > 0);
    for (int i = 0; i < stallCycles; i++) begin
      @(negedge clk);
      checkEq({tag, " stall ready"}, 64'(bus.multReady), 64'd1);
      checkEq({tag, " stall busy"}, 64'(bus.multBusy), 64'd0);
    end
    bus.StallE = 1'b0;
    @(negedge clk);
    bus.multStart = 1'b0;
    checkEq({tag, " busy"}, 64'(bus.multBusy), 64'd1);
    cycles = 0;
    while (!bus.multReady && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    checkEq({tag, " latency"}, 64'(cycles), 64'(refLatency(b, sgn)));
    bus.mfReg = MF_HI;
    #1 hiVal = bus.HiLoOut;
    bus.mfReg = MF_LO;
    #1 loVal = bus.HiLoOut;
    checkEq({tag, " hi"}, 64'(hiVal), 64'(exp[63:32]));
    checkEq({tag, " lo"}, 64'(loVal), 64'(exp[31:0]));
    bus.mfReg = 2'b11;
    #1 checkEq({tag, " mf11"}, 64'(bus.HiLoOut), 64'd0);
    bus.mfReg = 2'b00;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    bus.multStart  = 1'b0;
    bus.multSigned = 1'b0;
    bus.SrcAE      = '0;
    bus.SrcBE      = '0;
    bus.StallE     = 1'b0;
    bus.mfReg      = 2'b00;
    reset          = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    checkEq("rst ready", 64'(bus.multReady), 64'd1);
    checkEq("rst busy", 64'(bus.multBusy), 64'd0);
    bus.mfReg = MF_LO;
    #1 checkEq("rst lo", 64'(bus.HiLoOut), 64'd0);
    bus.mfReg = MF_HI;
    #1 checkEq("rst hi", 64'(bus.HiLoOut), 64'd0);
    bus.mfReg = 2'b00;

    // Directed corner products
    runMult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "multu_ff");
    runMult(32'hFFFF_FFF9, 32'h0000_0003, 1'b1, 0, "mult_m7x3");
    runMult(32'h8000_0000, 32'h8000_0000, 1'b1, 0, "mult_min");
    runMult(32'h8000_0000, 32'h8000_0000, 1'b0, 0, "multu_min");

    // Restart: a second start 10 cycles in wins
    @(negedge clk);
    bus.SrcAE      = 32'd5;
    bus.SrcBE      = 32'd6;
    bus.multSigned = 1'b0;
    bus.multStart  = 1'b1;
    @(negedge clk);
    bus.multStart = 1'b0;
    repeat (9) @(negedge clk);
    runMult(32'd2, 32'd3, 1'b0, 0, "restart");

    // Start held under StallE for 4 cycles
    runMult(32'd9, 32'd1, 1'b0, 4, "stall");

    // Random operands, back-to-back
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 4 == 0) rb = 32'($urandom_range(0, 15));
      runMult(ra, rb, rs, (i % 7 == 3) ? 2 : 0, $sformatf("rand%0d", i));
    end

    // Reset mid-computation clears HI/LO
    runMult(32'h1234_5678, 32'h0000_0009, 1'b0, 0, "pre_rst");
    bus.SrcAE      = 32'h1234_5678;
    bus.SrcBE      = 32'hFFFF_0000;
    bus.multSigned = 1'b0;
    bus.multStart  = 1'b1;
    @(negedge clk);
    bus.multStart = 1'b0;
    repeat (5) @(negedge clk);
    checkEq("midcalc busy", 64'(bus.multBusy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkEq("midrst ready", 64'(bus.multReady), 64'd1);
    checkEq("midrst busy", 64'(bus.multBusy), 64'd0);
    bus.mfReg = MF_HI;
    #1 checkEq("midrst hi", 64'(bus.HiLoOut), 64'd0);
    bus.mfReg = MF_LO;
    #1 checkEq("midrst lo", 64'(bus.HiLoOut), 64'd0);
    bus.mfReg = 2'b00;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
# mult_unit

Iterative 32×32 multiplier in the Execute stage producing the HI/LO pair for MULT/MULTU. It consumes operands and `multStart` from the Execute pipeline register. It drives `multReady` to the hazard unit, which stalls any MFHI/MFLO while a product is pending. MFHI/MFLO read the result through `HiLoOut`.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `multStart` input 1: Execute holds a MULT/MULTU this cycle.
- `multSigned` input 1: 1 means MULT (signed), 0 means MULTU.
- `SrcAE` input WIDTH: multiplicand, from the forwarded rs value.
- `SrcBE` input WIDTH: multiplier, from the forwarded rt value.
- `StallE` input 1: Execute stage is held by a memory stall.
- `mfReg` input 2: 01 selects MFHI, 10 selects MFLO, 00/11 selects none.
- `multReady` output 1: no product pending; HI/LO are valid.
- `multBusy` output 1: FSM is not IDLE.
- `HiLoOut` output WIDTH: selected HI/LO value; 0 when `mfReg` is 00 or 11.

## Operation
- FSM states:
  - IDLE: `multReady`=1.
  - CALC: one shift-add step per cycle.
  - SIGN: conditional negate, then HI/LO write.
- Start acceptance: a start is accepted when `multStart && !StallE`.
  - Capture |A| and |B|. Magnitude is taken only if `multSigned`; the operand is unchanged otherwise.
  - Capture `negResult` = `multSigned && (A[31]^B[31])`.
  - Clear the 64-bit accumulator and set `count`=0. Enter CALC.
- CALC step:
  - If multiplier LSB is 1, add the multiplicand into accumulator bits [63:32], using a 33-bit sum so the carry is kept.
  - Shift the accumulator and multiplier right by 1. Increment `count`.
  - After the step with `count`==31, go to SIGN.
- SIGN step:
  - Write HI={acc[63:32]} and LO={acc[31:0]}, two's-complement negated over 64 bits if `negResult`.
  - Return to IDLE.
- `multReady`=0 in CALC and SIGN. It is 1 from the cycle after the SIGN edge.
- Restart: an accepted start in CALC or SIGN aborts the current product. HI/LO are not written for it. Operands are recaptured and the FSM re-enters CALC with `count`=0 (last MULT wins).
- `StallE` high: `multStart` is ignored. A `multStart` held through the stall is accepted on the first cycle with `StallE`=0. An in-flight CALC continues during the stall.
- `HiLoOut` is a combinational mux of the HI/LO registers. During a computation it shows the old values; the hazard unit guarantees they are never consumed.
- Signed edge case: -2^31 × -2^31 gives HI=0x40000000, LO=0. The magnitude 0x80000000 must be treated as unsigned 2^31.

## Timing
- Reset values: state=IDLE, HI=0, LO=0, `count`=0, `multReady`=1, `multBusy`=0, `HiLoOut`=0.
- Reset asserted mid-CALC: product discarded, HI/LO cleared to 0 at the next edge.
- Latency, with the start accepted at edge E0:
  - CALC occupies edges E1–E32.
  - SIGN writes HI/LO at E33.
  - `multReady` rises after E33, giving 33 cycles from start to valid.
- The hazard stall condition `mfReg!=0 && (!multReady || multStart)` therefore releases an MFLO in the cycle after E33.
- Back-to-back: a start in the cycle `multReady` rises is accepted and `multReady` drops after that edge.

## Configuration
- `MULT_EARLY_EXIT_EN` defined:
  - In CALC, if the remaining shifted multiplier is 0 after a step, the accumulator is realigned by shifting right (31-`count`) and the FSM goes to SIGN.
  - Minimum latency is 2 cycles: B=0 or 1 gives start, one CALC, SIGN.
- `MULT_EARLY_EXIT_EN` undefined: fixed 33-cycle latency. No realign shifter is synthesised.

## Structure
- Shared package `mult_pkg` holds:
  - The state enum (IDLE, CALC, SIGN).
  - `MF_HI`=2'b01 and `MF_LO`=2'b10.
  - `MULT_WIDTH`=32 and `MULT_CNT_W`=5.
- Sub-module `shift_add_core` holds the accumulator, multiplier shift register, 33-bit adder and early-exit detect.
- The FSM, sign handling and HI/LO registers stay in `mult_unit`.

## Test plan
- Reset, then `mfReg`=10 → `multReady`=1, `HiLoOut`=0.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → after 33 cycles HI=0xFFFFFFFE, LO=0x00000001; `multReady` low for exactly 33 cycles.
- MULT -7×3 (0xFFFFFFF9, 0x3) → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULT 0x80000000×0x80000000 → HI=0x40000000, LO=0; MULTU with the same operands → HI=0x40000000, LO=0.
- Restart test, 5×6 then at cycle 10 a second start 2×3 → single result HI=0, LO=6 at 33 cycles after the second start.
- `multStart` held with `StallE`=1 for 4 cycles → no state change until `StallE` drops. Under `MULT_EARLY_EXIT_EN`, 9×1 → `multReady` returns after 2 cycles, LO=9.
